osd_regif_arb: RTL and testbench

OSD_REGIF_ARB -- requirements
Module: osd_regif_arb

---
 rtl/osd_regif_arb.sv | 182 ++++++++++++++++++
 tb/tb_osd_regif_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/osd_regif_arb.sv
// osd_regif_arb: round-robin arbiter that lets NUM_REQ requesters share one
// register bus. Each access goes IDLE -> BUSY -> RELEASE, so a requester is
// never granted twice back to back without a one-cycle bus gap.
// Optional feature macro: OSD_REGIF_ARB_TIMEOUT_EN. When it is defined, a
// granted access that gets no response within TIMEOUT cycles ends with an
// error strobe.
module osd_regif_arb #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_request,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [16*NUM_REQ-1:0] req_addr,
    input  logic [2*NUM_REQ-1:0]  req_size,
    input  logic [16*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    req_err,
    output logic [15:0]           req_rdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  reg_request,
    output logic                  reg_write,
    output logic [15:0]           reg_addr,
    output logic [1:0]            reg_size,
    output logic [15:0]           reg_wdata,
    input  logic                  reg_ack,
    input  logic                  reg_err,
    input  logic [15:0]           reg_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Last BUSY-cycle count value that still counts as "in time".
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t               state_r;
    logic [1:0]           ptr_r;
    logic [1:0]           gidx_r;
    logic [NUM_REQ-1:0]   grant_r;

    // Requester fields padded to four lanes so a 2-bit index is always legal.
    logic [3:0]           req_pad_s;
    logic [3:0]           write_pad_s;
    logic [63:0]          addr_pad_s;
    logic [63:0]          wdata_pad_s;
    logic [7:0]           size_pad_s;

    logic                 pick_found_s;
    logic [1:0]           pick_idx_s;
    logic [1:0]           cand_s;
    logic [3:0]           pick_onehot_s;
    logic [3:0]           owner_onehot_s;
    logic [1:0]           next_ptr_s;

    logic                 busy_s;
    logic                 live_s;
    logic                 resp_ok_s;
    logic                 ack_hit_s;
    logic                 err_hit_s;
    logic                 to_hit_s;
    logic                 done_s;

`ifdef OSD_REGIF_ARB_TIMEOUT_EN
    logic [15:0]          cnt_r;
`else
    logic                 unused_timeout_s;
    assign unused_timeout_s = ^TO_LAST;
`endif

    assign req_pad_s   = 4'(req_request);
    assign write_pad_s = 4'(req_write);
    assign addr_pad_s  = 64'(req_addr);
    assign wdata_pad_s = 64'(req_wdata);
    assign size_pad_s  = 8'(req_size);

    // Round-robin search: first requesting index at or after ptr, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = 2'd0;
        cand_s       = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = 2'((32'(ptr_r) + 32'(k)) % NUM_REQ);
            if (!pick_found_s && req_pad_s[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        pick_onehot_s  = 4'b0001 << pick_idx_s;
        owner_onehot_s = 4'b0001 << gidx_r;
        next_ptr_s     = (gidx_r == 2'(NUM_REQ - 1)) ? 2'd0 : gidx_r + 2'd1;
    end

    // Response decode for the current owner; an error beats a simultaneous
    // ack, and a response during reset produces no strobe.
    always_comb begin
        busy_s    = (state_r == BUSY);
        live_s    = busy_s && req_pad_s[gidx_r];
        resp_ok_s = live_s && !rst;
        err_hit_s = resp_ok_s && reg_err;
        ack_hit_s = resp_ok_s && reg_ack && !reg_err;
`ifdef OSD_REGIF_ARB_TIMEOUT_EN
        to_hit_s  = resp_ok_s && !reg_ack && !reg_err && (cnt_r == TO_LAST);
`else
        to_hit_s  = 1'b0;
`endif
        done_s    = busy_s && (!req_pad_s[gidx_r] || reg_ack || reg_err || to_hit_s);
    end

    // Arbitration FSM: owner selection, grant register, pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            gidx_r  <= 2'd0;
            grant_r <= '0;
`ifdef OSD_REGIF_ARB_TIMEOUT_EN
            cnt_r   <= 16'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        state_r <= BUSY;
                        gidx_r  <= pick_idx_s;
                        grant_r <= pick_onehot_s[NUM_REQ-1:0];
`ifdef OSD_REGIF_ARB_TIMEOUT_EN
                        cnt_r   <= 16'd0;
`endif
                    end else begin
                        grant_r <= '0;
                    end
                end
                BUSY: begin
                    if (done_s) begin
                        state_r <= RELEASE;
                        ptr_r   <= next_ptr_s;
                        grant_r <= '0;
                    end else begin
`ifdef OSD_REGIF_ARB_TIMEOUT_EN
                        cnt_r   <= cnt_r + 16'd1;
`endif
                        grant_r <= grant_r;
                    end
                end
                RELEASE: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Shared bus request muxes the owner's fields while it still requests.
    always_comb begin
        reg_request = live_s;
        reg_write   = live_s & write_pad_s[gidx_r];
        reg_addr    = live_s ? addr_pad_s[{gidx_r, 4'd0} +: 16] : 16'd0;
        reg_size    = live_s ? size_pad_s[{gidx_r, 1'b0} +: 2] : 2'd0;
        reg_wdata   = live_s ? wdata_pad_s[{gidx_r, 4'd0} +: 16] : 16'd0;
    end

    // Completion strobes go only to the owner; read data only on a response.
    always_comb begin
        req_ack   = ack_hit_s ? owner_onehot_s[NUM_REQ-1:0] : '0;
        req_err   = (err_hit_s || to_hit_s) ? owner_onehot_s[NUM_REQ-1:0] : '0;
        req_rdata = (ack_hit_s || err_hit_s) ? reg_rdata : 16'd0;
    end

    assign grant = grant_r;

endmodule

// File: tb/tb_osd_regif_arb.sv
// tb_osd_regif_arb: directed table-driven bench for osd_regif_arb with
// NUM_REQ=2, TIMEOUT=4. Inputs are driven 1 ns after the rising edge and
// outputs are sampled 3 ns later, well before the next edge.
module tb_osd_regif_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_request;
    logic [1:0]  req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_size;
    logic [31:0] req_wdata;
    logic [1:0]  req_ack;
    logic [1:0]  req_err;
    logic [15:0] req_rdata;
    logic [1:0]  grant;
    logic        reg_request;
    logic        reg_write;
    logic [15:0] reg_addr;
    logic [1:0]  reg_size;
    logic [15:0] reg_wdata;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    osd_regif_arb #(.NUM_REQ(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_request(req_request), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
        .grant(grant),
        .reg_request(reg_request), .reg_write(reg_write), .reg_addr(reg_addr),
        .reg_size(reg_size), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        r_ack;
        logic        r_err;
        logic [15:0] r_rdata;
        logic [1:0]  e_grant;
        logic        e_rreq;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock: wait for the edge, drive the inputs, let them settle.
    task automatic cyc(input logic r, input logic [1:0] rq, input logic ra, input logic re,
                       input logic [15:0] rd);
        @(posedge clk);
        #1;
        rst         = r;
        req_request = rq;
        reg_ack     = ra;
        reg_err     = re;
        reg_rdata   = rd;
        #3;
    endtask

    task automatic do_reset();
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 16'h0000);
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic ra,
                                input logic re, input logic [15:0] rd, input logic [1:0] eg,
                                input logic erq, input logic [1:0] ea, input logic [1:0] ee,
                                input logic [15:0] erd);
        vec_t v;
        v.rst = r; v.req = rq; v.r_ack = ra; v.r_err = re; v.r_rdata = rd;
        v.e_grant = eg; v.e_rreq = erq; v.e_ack = ea; v.e_err = ee; v.e_rdata = erd;
        return v;
    endfunction

    task automatic apply_row(input int i, input vec_t v);
        logic        ew;
        logic [15:0] ea;
        logic [1:0]  es;
        logic [15:0] ed;
        cyc(v.rst, v.req, v.r_ack, v.r_err, v.r_rdata);
        // Requester 0 reads 0x0200 size 1; requester 1 writes 0x5A5A to 0x0A0A size 2.
        if (v.e_rreq && v.e_grant == 2'b01) begin
            ew = 1'b0; ea = 16'h0200; es = 2'd1; ed = 16'h0000;
        end else if (v.e_rreq && v.e_grant == 2'b10) begin
            ew = 1'b1; ea = 16'h0A0A; es = 2'd2; ed = 16'h5A5A;
        end else begin
            ew = 1'b0; ea = 16'h0000; es = 2'd0; ed = 16'h0000;
        end
        chk($sformatf("v%0d grant", i),       32'(grant),       32'(v.e_grant));
        chk($sformatf("v%0d reg_request", i), 32'(reg_request), 32'(v.e_rreq));
        chk($sformatf("v%0d reg_write", i),   32'(reg_write),   32'(ew));
        chk($sformatf("v%0d reg_addr", i),    32'(reg_addr),    32'(ea));
        chk($sformatf("v%0d reg_size", i),    32'(reg_size),    32'(es));
        chk($sformatf("v%0d reg_wdata", i),   32'(reg_wdata),   32'(ed));
        chk($sformatf("v%0d req_ack", i),     32'(req_ack),     32'(v.e_ack));
        chk($sformatf("v%0d req_err", i),     32'(req_err),     32'(v.e_err));
        chk($sformatf("v%0d req_rdata", i),   32'(req_rdata),   32'(v.e_rdata));
    endtask

    logic [1:0] alt_grant[13];
    logic [1:0] alt_ack[13];
    logic       alt_rack[13];
    logic       alt_rst[13];

    initial begin
        rst = 1'b1; req_request = 2'b00; reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = 16'h0000;
        req_write = 2'b10;
        req_addr  = {16'h0A0A, 16'h0200};
        req_size  = {2'd2, 2'd1};
        req_wdata = {16'h5A5A, 16'h0000};

        //              rst   req    ack   err   rdata     grant  rreq  ack    err    rdata
        vecs[0]  = mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[1]  = mk(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[2]  = mk(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 2'b00, 16'h0000);
        vecs[3]  = mk(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 2'b00, 16'h0000);
        vecs[4]  = mk(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 2'b00, 16'h0000);
        vecs[5]  = mk(1'b0, 2'b01, 1'b1, 1'b0, 16'hBEEF, 2'b01, 1'b1, 2'b01, 2'b00, 16'hBEEF);
        vecs[6]  = mk(1'b0, 2'b00, 1'b0, 1'b0, 16'hBEEF, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[7]  = mk(1'b0, 2'b00, 1'b1, 1'b0, 16'h1234, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[8]  = mk(1'b0, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[9]  = mk(1'b0, 2'b10, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b1, 2'b00, 2'b00, 16'h0000);
        vecs[10] = mk(1'b0, 2'b10, 1'b1, 1'b1, 16'hDEAD, 2'b10, 1'b1, 2'b00, 2'b10, 16'hDEAD);
        vecs[11] = mk(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[12] = mk(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[13] = mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[14] = mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[15] = mk(1'b0, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 16'h0000);
        vecs[16] = mk(1'b0, 2'b11, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b1, 2'b00, 2'b00, 16'h0000);
        vecs[17] = mk(1'b0, 2'b11, 1'b1, 1'b0, 16'hCAFE, 2'b10, 1'b1, 2'b10, 2'b00, 16'hCAFE);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            apply_row(i, vecs[i]);
        end

        // Both requesters held: grants alternate with RELEASE+IDLE gaps, then
        // a reset in BUSY (with a coincident ack) hands the next grant to req 0.
        alt_grant = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01,
                      2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
        alt_ack   = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01,
                      2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        alt_rack  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        alt_rst   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 13; c++) begin
            cyc(alt_rst[c], 2'b11, alt_rack[c], 1'b0, 16'h0101);
            chk($sformatf("alt%0d grant", c),       32'(grant),       32'(alt_grant[c]));
            chk($sformatf("alt%0d reg_request", c), 32'(reg_request), 32'(alt_grant[c] != 2'b00));
            chk($sformatf("alt%0d req_ack", c),     32'(req_ack),     32'(alt_ack[c]));
            chk($sformatf("alt%0d req_err", c),     32'(req_err),     32'h0);
        end

`ifdef OSD_REGIF_ARB_TIMEOUT_EN
        // No response: error in the 4th BUSY cycle, later acks ignored.
        do_reset();
        cyc(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        chk("to idle grant", 32'(grant), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            cyc(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("to%0d grant", c),   32'(grant),   32'h1);
            chk($sformatf("to%0d req_err", c), 32'(req_err), 32'h0);
        end
        cyc(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        chk("to4 req_err", 32'(req_err), 32'h1);
        chk("to4 req_ack", 32'(req_ack), 32'h0);
        for (int c = 5; c <= 6; c++) begin
            cyc(1'b0, 2'b00, 1'b1, 1'b0, 16'h7777);
            chk($sformatf("late%0d req_ack", c),   32'(req_ack),   32'h0);
            chk($sformatf("late%0d req_err", c),   32'(req_err),   32'h0);
            chk($sformatf("late%0d req_rdata", c), 32'(req_rdata), 32'h0);
        end
        // An ack in the timeout cycle wins over the timeout.
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            cyc(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        end
        cyc(1'b0, 2'b01, 1'b1, 1'b0, 16'h4242);
        chk("towin req_ack", 32'(req_ack), 32'h1);
        chk("towin req_err", 32'(req_err), 32'h0);
        chk("towin req_rdata", 32'(req_rdata), 32'h4242);
`else
        // Without the timeout feature BUSY waits for as long as it takes.
        do_reset();
        cyc(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        for (int c = 1; c <= 10; c++) begin
            cyc(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("wait%0d reg_request", c), 32'(reg_request), 32'h1);
            chk($sformatf("wait%0d req_err", c),     32'(req_err),     32'h0);
        end
        cyc(1'b0, 2'b01, 1'b1, 1'b0, 16'h4242);
        chk("wait req_ack", 32'(req_ack), 32'h1);
        chk("wait req_rdata", 32'(req_rdata), 32'h4242);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
